// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, bit positions
// and the CTRL flag layout.
package mmio_timer_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int CTRL_PRESCALE_LSB    = 16;

    localparam int STATUS_MATCH_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    // Single-bit CTRL fields; PRESCALE is held separately because its width is a parameter.
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_flags_t;

endpackage

// File: rtl/mmio_timer_slave_tick_prescaler.sv
// Prescaler for the timer: emits a one-cycle tick every PRESCALE+1 enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] pcnt;

    assign tick = enable && (pcnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clear || !enable || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer_slave.sv
// Timer/counter slave on the data-memory bus: CTRL/COUNT/COMPARE/STATUS registers,
// prescaled up-counter with compare, sticky MATCH/OVF flags and a level irq.
module mmio_timer_slave
    import mmio_timer_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  hsel,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
);

    // Bus protocol: no handshake. A write commits on the rising edge where we=1
    // (no stall, no response); a read is combinational while hsel=1 and has no
    // side effects. Only address[3:2] selects a register.

    ctrl_flags_t               ctrl;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [DATA_WIDTH-1:0]     count;
    logic [DATA_WIDTH-1:0]     compare;
    logic                      match_flag;
    logic                      ovf_flag;

    logic [1:0] reg_sel;
    logic       wr_ctrl, wr_count, wr_compare, wr_status;
    logic       tick;
    logic       count_hit, count_max;
    logic       set_match, set_ovf;
    logic       clr_match, clr_ovf;
    logic       unused_addr_bits;

    assign reg_sel          = address[3:2];
    assign unused_addr_bits = ^{address[31:4], address[1:0]};

    assign wr_ctrl    = we && (reg_sel == REG_CTRL);
    assign wr_count   = we && (reg_sel == REG_COUNT);
    assign wr_compare = we && (reg_sel == REG_COMPARE);
    assign wr_status  = we && (reg_sel == REG_STATUS);

    tick_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (ctrl.en),
        .clear   (wr_ctrl),
        .prescale(prescale),
        .tick    (tick)
    );

    assign count_hit = (count == compare);
    assign count_max = (count == {DATA_WIDTH{1'b1}});

    // A COUNT write in the same cycle suppresses the tick entirely, flags included.
    // Reload on match takes precedence over overflow at all-ones.
    assign set_match = tick && !wr_count && count_hit;
    assign set_ovf   = tick && !wr_count && count_max && !(count_hit && ctrl.auto_reload);

    assign clr_match = wr_status && wd[STATUS_MATCH_BIT];
    assign clr_ovf   = wr_status && wd[STATUS_OVF_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            prescale <= '0;
        end else if (wr_ctrl) begin
            ctrl.en          <= wd[CTRL_EN_BIT];
            ctrl.auto_reload <= wd[CTRL_AUTO_RELOAD_BIT];
            ctrl.irq_en      <= wd[CTRL_IRQ_EN_BIT];
            prescale         <= wd[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wd;
        end else if (tick) begin
            if (count_hit && ctrl.auto_reload) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            compare <= '0;
        end else if (wr_compare) begin
            compare <= wd;
        end
    end

    // Set beats write-1-clear when both land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            match_flag <= set_match || (match_flag && !clr_match);
            ovf_flag   <= set_ovf || (ovf_flag && !clr_ovf);
        end
    end

    assign irq = match_flag && ctrl.irq_en;

    always_comb begin
        rd = '0;
        if (hsel) begin
            case (reg_sel)
                REG_CTRL: begin
                    rd[CTRL_EN_BIT]                         = ctrl.en;
                    rd[CTRL_AUTO_RELOAD_BIT]                = ctrl.auto_reload;
                    rd[CTRL_IRQ_EN_BIT]                     = ctrl.irq_en;
                    rd[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH] = prescale;
                end
                REG_COUNT:   rd = count;
                REG_COMPARE: rd = compare;
                default: begin
                    rd[STATUS_MATCH_BIT] = match_flag;
                    rd[STATUS_OVF_BIT]   = ovf_flag;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Directed bench for mmio_timer_slave: reset, match, prescale/auto-reload,
// overflow, same-edge collisions and bus select.
module tb_mmio_timer_slave;

    logic        clk;
    logic        rst_n;
    logic [31:0] wd;
    logic [31:0] address;
    logic        we;
    logic        hsel;
    logic [31:0] rd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_CTRL    = 32'h0;
    localparam logic [31:0] A_COUNT   = 32'h4;
    localparam logic [31:0] A_COMPARE = 32'h8;
    localparam logic [31:0] A_STATUS  = 32'hC;

    mmio_timer_slave dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wd     (wd),
        .address(address),
        .we     (we),
        .hsel   (hsel),
        .rd     (rd),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address = a;
        wd      = d;
        we      = 1'b1;
        step(1);
        we      = 1'b0;
        wd      = '0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a;
        hsel    = 1'b1;
        #2;
        check(tag, rd, exp);
        hsel    = 1'b0;
    endtask

    task automatic irq_check(input string tag, input logic exp);
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        rst_n   = 1'b0;
        wd      = '0;
        address = '0;
        we      = 1'b0;
        hsel    = 1'b0;

        // Reset state
        step(3);
        read_check("rst_rd_ctrl_in_reset", A_CTRL, 32'h0);
        rst_n = 1'b1;
        step(1);
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_count", A_COUNT, 32'h0);
        read_check("rst_compare", A_COMPARE, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0);
        irq_check("rst_irq", 1'b0);

        // Basic match, PRESCALE=0, IRQ_EN
        bus_write(A_COMPARE, 32'd5);
        bus_write(A_CTRL, 32'h5);
        read_check("basic_ctrl_rb", A_CTRL, 32'h5);
        read_check("basic_count0", A_COUNT, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            read_check($sformatf("basic_count%0d", i), A_COUNT, i);
            irq_check($sformatf("basic_irq_low%0d", i), 1'b0);
        end
        step(1);
        read_check("basic_count6", A_COUNT, 32'd6);
        read_check("basic_status_match", A_STATUS, 32'h1);
        irq_check("basic_irq_high", 1'b1);
        bus_write(A_STATUS, 32'h1);
        read_check("basic_status_cleared", A_STATUS, 32'h0);
        irq_check("basic_irq_cleared", 1'b0);

        // Prescale=3 with auto-reload, compare=2
        bus_write(A_CTRL, 32'h0);
        bus_write(A_COUNT, 32'h0);
        bus_write(A_COMPARE, 32'd2);
        bus_write(A_CTRL, 32'h0003_0003);
        read_check("ps_ctrl_rb", A_CTRL, 32'h0003_0003);
        read_check("ps_count_e0", A_COUNT, 32'd0);
        step(3);
        read_check("ps_count_e3", A_COUNT, 32'd0);
        step(1);
        read_check("ps_count_e4", A_COUNT, 32'd1);
        step(3);
        read_check("ps_count_e7", A_COUNT, 32'd1);
        step(1);
        read_check("ps_count_e8", A_COUNT, 32'd2);
        read_check("ps_status_before", A_STATUS, 32'h0);
        step(4);
        read_check("ps_count_reload", A_COUNT, 32'd0);
        read_check("ps_status_match", A_STATUS, 32'h1);
        irq_check("ps_irq_disabled", 1'b0);
        bus_write(A_STATUS, 32'h1);
        read_check("ps_status_clr", A_STATUS, 32'h0);
        step(3);
        read_check("ps_count_e16", A_COUNT, 32'd1);
        step(4);
        read_check("ps_count_e20", A_COUNT, 32'd2);
        step(4);
        read_check("ps_count_reload2", A_COUNT, 32'd0);
        read_check("ps_status_match2", A_STATUS, 32'h1);

        // Overflow
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h3);
        bus_write(A_COUNT, 32'hFFFF_FFFF);
        bus_write(A_COMPARE, 32'h10);
        bus_write(A_CTRL, 32'h1);
        read_check("ovf_count_max", A_COUNT, 32'hFFFF_FFFF);
        step(1);
        read_check("ovf_count_wrap", A_COUNT, 32'h0);
        read_check("ovf_status", A_STATUS, 32'h2);
        irq_check("ovf_irq", 1'b0);
        bus_write(A_STATUS, 32'h0);
        read_check("ovf_w0_noeffect", A_STATUS, 32'h2);
        bus_write(A_STATUS, 32'h2);
        read_check("ovf_w1c", A_STATUS, 32'h0);

        // Collision: COUNT write beats a matching tick
        bus_write(A_CTRL, 32'h0);
        bus_write(A_COMPARE, 32'd3);
        bus_write(A_COUNT, 32'd3);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_COUNT, 32'h100);
        read_check("col_count_write_wins", A_COUNT, 32'h100);
        read_check("col_no_match", A_STATUS, 32'h0);

        // Collision: new match beats W1C on the same edge
        bus_write(A_CTRL, 32'h0);
        bus_write(A_COUNT, 32'h0);
        bus_write(A_COMPARE, 32'h0);
        bus_write(A_CTRL, 32'h3);
        step(1);
        read_check("col_match_set", A_STATUS, 32'h1);
        bus_write(A_STATUS, 32'h1);
        read_check("col_set_beats_clr", A_STATUS, 32'h1);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);
        read_check("col_final_clr", A_STATUS, 32'h0);

        // Bus select and write strobe
        bus_write(A_COUNT, 32'h1234_5678);
        bus_write(A_COMPARE, 32'h0000_00AB);
        address = A_COUNT;
        hsel    = 1'b0;
        #2;
        check("sel_hsel0_rd", rd, 32'h0);
        step(1);
        wd = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            address = 32'(i * 4);
            step(1);
        end
        wd = '0;
        read_check("we0_ctrl", A_CTRL, 32'h0);
        read_check("we0_count", A_COUNT, 32'h1234_5678);
        read_check("we0_compare", A_COMPARE, 32'h0000_00AB);
        read_check("we0_status", A_STATUS, 32'h0);

        // Asynchronous reset mid-count with irq high
        bus_write(A_COUNT, 32'h0);
        bus_write(A_COMPARE, 32'h0);
        bus_write(A_CTRL, 32'h7);
        step(1);
        irq_check("arst_irq_before", 1'b1);
        #2;
        rst_n   = 1'b0;
        address = A_COUNT;
        hsel    = 1'b1;
        #1;
        irq_check("arst_irq_immediate", 1'b0);
        check("arst_rd_immediate", rd, 32'h0);
        hsel = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        read_check("arst_ctrl", A_CTRL, 32'h0);
        read_check("arst_count", A_COUNT, 32'h0);
        read_check("arst_compare", A_COMPARE, 32'h0);
        read_check("arst_status", A_STATUS, 32'h0);
        irq_check("arst_irq", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
